// File: rtl/mem_lsu_if.sv
// Request/response and BRAM-port bundle for mem_lsu.
// slave is the LSU's view; master is the core-plus-BRAM environment.
interface mem_lsu_if #(
   parameter int ADDR_W = 13
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rd_data;
   logic              mem_rd_valid;
   logic              mem_wr_en;
   logic [31:0]       mem_wr_data;

   // Handshake: a request transfers on a rising edge where req_valid & req_ready;
   // resp_valid is a single-cycle pulse with no backpressure.
   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  mem_rd_data, mem_rd_valid,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output mem_rd_data, mem_rd_valid,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word requests onto a word-wide BRAM port with RMW sub-word stores.
// Optional LSU_TIMEOUT_EN: abandon RD_WAIT with resp_err after TIMEOUT cycles without mem_rd_valid.
module mem_lsu #(
   parameter int ADDR_W  = 13,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_lsu_if.slave   bus,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_WRITE   = 3'd2,
      S_RESP    = 3'd3
   } state_t;

   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
`ifdef LSU_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   state_t            state, state_n;
   logic              cap_we;
   logic [1:0]        cap_size;
   logic              cap_uns;
   logic [15:0]       cap_wdata;
   logic [1:0]        cap_off;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              capture;
   logic              misalign;

   logic              req_ready_r, req_ready_n;
   logic              resp_valid_r, resp_valid_n;
   logic [31:0]       resp_rdata_r, resp_rdata_n;
   logic              resp_err_r, resp_err_n;
   logic              rd_en_r, rd_en_n;
   logic              wr_en_r, wr_en_n;
   logic [31:0]       wr_data_r, wr_data_n;
   logic [ADDR_W-1:0] addr_r;

   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_ext;
   logic [31:0]       merged;

   assign misalign = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

   // Lane extraction and merge act on the word returned by the BRAM in RD_WAIT.
   always_comb begin
      byte_sel = bus.mem_rd_data[{cap_off, 3'b000} +: 8];
      half_sel = cap_off[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
      case (cap_size)
         2'b00:   load_ext = {{24{~cap_uns & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~cap_uns & half_sel[15]}}, half_sel};
         default: load_ext = bus.mem_rd_data;
      endcase
      merged = bus.mem_rd_data;
      if (cap_size == 2'b00) begin
         merged[{cap_off, 3'b000} +: 8] = cap_wdata[7:0];
      end else if (cap_off[1]) begin
         merged[31:16] = cap_wdata;
      end else begin
         merged[15:0] = cap_wdata;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      capture      = 1'b0;
      req_ready_n  = 1'b0;
      resp_valid_n = 1'b0;
      resp_rdata_n = 32'h0;
      resp_err_n   = 1'b0;
      rd_en_n      = 1'b0;
      wr_en_n      = 1'b0;
      wr_data_n    = wr_data_r;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               capture = 1'b1;
               cnt_n   = '0;
               if (misalign) begin
                  state_n      = S_RESP;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
               end else if (bus.req_we && bus.req_size == 2'b10) begin
                  state_n   = S_WRITE;
                  wr_en_n   = 1'b1;
                  wr_data_n = bus.req_wdata;
               end else begin
                  state_n = S_RD_WAIT;
                  rd_en_n = 1'b1;
               end
            end else begin
               req_ready_n = 1'b1;
            end
         end
         S_RD_WAIT: begin
            cnt_n = cnt + 1'b1;
            if (bus.mem_rd_valid) begin
               if (!cap_we) begin
                  // Loads respond straight from RD_WAIT so the next request can be taken alongside resp_valid.
                  state_n      = S_IDLE;
                  req_ready_n  = 1'b1;
                  resp_valid_n = 1'b1;
                  resp_rdata_n = load_ext;
               end else begin
                  state_n   = S_WRITE;
                  wr_en_n   = 1'b1;
                  wr_data_n = merged;
               end
            end else if (TO_EN && cnt == CNT_W'(TIMEOUT)) begin
               state_n      = S_RESP;
               resp_valid_n = 1'b1;
               resp_err_n   = 1'b1;
            end
         end
         S_WRITE: begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
         end
         S_RESP: begin
            state_n     = S_IDLE;
            req_ready_n = 1'b1;
         end
         default: begin
            state_n     = S_IDLE;
            req_ready_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cap_we       <= 1'b0;
         cap_size     <= 2'b00;
         cap_uns      <= 1'b0;
         cap_wdata    <= 16'h0;
         cap_off      <= 2'b00;
         addr_r       <= '0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0;
         resp_err_r   <= 1'b0;
         rd_en_r      <= 1'b0;
         wr_en_r      <= 1'b0;
         wr_data_r    <= 32'h0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         req_ready_r  <= req_ready_n;
         resp_valid_r <= resp_valid_n;
         resp_rdata_r <= resp_rdata_n;
         resp_err_r   <= resp_err_n;
         rd_en_r      <= rd_en_n;
         wr_en_r      <= wr_en_n;
         wr_data_r    <= wr_data_n;
         if (capture) begin
            cap_we    <= bus.req_we;
            cap_size  <= bus.req_size;
            cap_uns   <= bus.req_unsigned;
            cap_wdata <= bus.req_wdata[15:0];
            cap_off   <= bus.req_addr[1:0];
            addr_r    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
         end
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.resp_valid  = resp_valid_r;
   assign bus.resp_rdata  = resp_rdata_r;
   assign bus.resp_err    = resp_err_r;
   assign bus.mem_rd_en   = rd_en_r;
   assign bus.mem_wr_en   = wr_en_r;
   assign bus.mem_wr_data = wr_data_r;
   assign bus.mem_addr    = addr_r;
   assign dbg_state       = state;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed test-plan cases plus random traffic against a word-array model.
module tb_mem_lsu;
   localparam int ADDR_W  = 13;
   localparam int TIMEOUT = 15;
   localparam int WORDS   = 2048;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

   mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   logic [31:0] bram    [0:WORDS-1];
   logic [31:0] ref_mem [0:WORDS-1];
   logic bram_load = 1'b0;
   logic bram_mute = 1'b0;

   // BRAM: one-cycle read latency, full-word writes.
   always @(posedge clk) begin
      bus.mem_rd_valid <= bus.mem_rd_en && !bram_mute;
      if (bus.mem_rd_en) bus.mem_rd_data <= bram[bus.mem_addr[ADDR_W-1:2]];
      if (bram_load) begin
         for (int i = 0; i < WORDS; i++) bram[i] <= ref_mem[i];
      end else if (bus.mem_wr_en) begin
         bram[bus.mem_addr[ADDR_W-1:2]] <= bus.mem_wr_data;
      end
   end

   int rd_cnt = 0;
   int wr_cnt = 0;
   logic both_seen = 1'b0;
   logic [31:0] wr_seen = 32'h0;
   logic [ADDR_W-1:0] addr_seen = '0;

   always @(negedge clk) begin
      if (bus.mem_rd_en && bus.mem_wr_en) both_seen = 1'b1;
      if (bus.mem_rd_en) begin
         rd_cnt++;
         addr_seen = bus.mem_addr;
      end
      if (bus.mem_wr_en) begin
         wr_cnt++;
         wr_seen = bus.mem_wr_data;
         addr_seen = bus.mem_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input string nm);
      logic [31:0] w, v, mask, exp_rdata, exp_word;
      int sh, exp_lat, exp_rds, exp_wrs, lat, n;
      logic exp_err, mis, got;
      w    = ref_mem[a[ADDR_W-1:2]];
      sh   = 8 * int'(a[1:0]);
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      mis  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      exp_word  = w;
      if (mis) begin
         exp_lat = 1; exp_err = 1'b1; exp_rds = 0; exp_wrs = 0;
      end else if (!we && bram_mute || we && sz != 2'd2 && bram_mute) begin
         exp_lat = TIMEOUT + 2; exp_err = 1'b1; exp_rds = 1; exp_wrs = 0;
      end else if (!we) begin
         v = (w >> sh) & mask;
         if (!uns && sz == 2'd0 && v[7]) v = v | 32'hFFFF_FF00;
         if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
         exp_rdata = v;
         exp_lat = 3; exp_rds = 1; exp_wrs = 0;
      end else begin
         exp_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
         exp_lat = (sz == 2'd2) ? 2 : 4;
         exp_rds = (sz == 2'd2) ? 0 : 1;
         exp_wrs = 1;
      end
      exp_q.push_back(exp_rdata);

      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({nm, ":ready_wait"}, 32'(bus.req_ready), 32'h1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_addr     = a;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_wdata    = wd;
      rd_cnt = 0;
      wr_cnt = 0;
      both_seen = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;

      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) got = 1'b1;
      end
      check({nm, ":resp_seen"}, 32'(got), 32'h1);
      check({nm, ":latency"}, 32'(lat), 32'(exp_lat));
      check({nm, ":err"}, 32'(bus.resp_err), 32'(exp_err));
      check({nm, ":rdata"}, bus.resp_rdata, exp_q.pop_front());
      check({nm, ":ready_at_resp"}, 32'(bus.req_ready), (!we && !exp_err) ? 32'h1 : 32'h0);
      check({nm, ":rd_strobes"}, 32'(rd_cnt), 32'(exp_rds));
      check({nm, ":wr_strobes"}, 32'(wr_cnt), 32'(exp_wrs));
      check({nm, ":strobe_excl"}, 32'(both_seen), 32'h0);
      if (exp_wrs != 0) check({nm, ":wr_data"}, wr_seen, exp_word);
      if (exp_rds + exp_wrs != 0) check({nm, ":mem_addr"}, 32'(addr_seen), 32'(a & ~13'h3));
      @(negedge clk);
      check({nm, ":pulse"}, 32'(bus.resp_valid), 32'h0);
      ref_mem[a[ADDR_W-1:2]] = exp_word;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, ":req_ready"}, 32'(bus.req_ready), 32'h1);
      check({nm, ":resp_valid"}, 32'(bus.resp_valid), 32'h0);
      check({nm, ":resp_rdata"}, bus.resp_rdata, 32'h0);
      check({nm, ":resp_err"}, 32'(bus.resp_err), 32'h0);
      check({nm, ":mem_rd_en"}, 32'(bus.mem_rd_en), 32'h0);
      check({nm, ":mem_wr_en"}, 32'(bus.mem_wr_en), 32'h0);
      check({nm, ":mem_addr"}, 32'(bus.mem_addr), 32'h0);
      check({nm, ":mem_wr_data"}, bus.mem_wr_data, 32'h0);
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [1:0] rs;
      int nbad;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_addr     = '0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_wdata    = 32'h0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
      ref_mem[4] = 32'h8899_AABB;

      // Clock/reset
      bram_load = 1'b1;
      repeat (3) @(posedge clk);
      bram_load = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases on the word at 0x010
      do_req(1'b0, 13'h013, 2'd0, 1'b0, 32'h0, "lb_013");
      do_req(1'b0, 13'h012, 2'd0, 1'b1, 32'h0, "lbu_012");
      do_req(1'b0, 13'h012, 2'd1, 1'b0, 32'h0, "lh_012");
      do_req(1'b0, 13'h010, 2'd1, 1'b1, 32'h0, "lhu_010");
      do_req(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, "lw_010");
      do_req(1'b1, 13'h011, 2'd0, 1'b0, 32'h1234_5655, "sb_011");
      check("sb_011:bram_word", bram[4], 32'h8899_55BB);
      do_req(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, "lw_after_sb");
      do_req(1'b1, 13'h020, 2'd2, 1'b0, 32'hDEAD_BEEF, "sw_020");
      check("sw_020:bram_word", bram[8], 32'hDEAD_BEEF);
      do_req(1'b1, 13'h011, 2'd1, 1'b0, 32'hCAFE_F00D, "sh_011_mis");
      do_req(1'b0, 13'h022, 2'd2, 1'b0, 32'h0, "lw_022_mis");
      do_req(1'b0, 13'h010, 2'd3, 1'b0, 32'h0, "size3_mis");
      do_req(1'b1, 13'h016, 2'd1, 1'b0, 32'h0000_7E81, "sh_016");

      // Reset in C2 of a byte store abandons the write
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 13'h011;
      bus.req_size  = 2'd0;
      bus.req_wdata = 32'h0000_00EE;
      wr_cnt = 0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_reset:wr_strobes", 32'(wr_cnt), 32'h0);
      check("mid_reset:bram_word", bram[4], ref_mem[4]);

`ifdef LSU_TIMEOUT_EN
      bram_mute = 1'b1;
      do_req(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, "lw_timeout");
      do_req(1'b1, 13'h012, 2'd0, 1'b0, 32'h0000_0011, "sb_timeout");
      bram_mute = 1'b0;
      repeat (2) @(negedge clk);
`endif

      // Random traffic over the low 256 bytes
      for (int t = 0; t < 80; t++) begin
         ra = 13'($urandom_range(0, 255));
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (rs == 2'd3) rs = 2'($urandom_range(0, 2));
            if (rs == 2'd1) ra[0] = 1'b0;
            if (rs == 2'd2) ra[1:0] = 2'b00;
         end
         do_req(1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), $urandom, $sformatf("rnd%0d", t));
      end

      nbad = 0;
      for (int i = 0; i < 64; i++) if (bram[i] !== ref_mem[i]) nbad++;
      check("bram_final", 32'(nbad), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
